// File: rtl/pto_capture.sv
// pto_capture: step pulse-train monitor measuring period/high time in us, counting pulses,
// classifying motion (accel/cruise/decel) and detecting stop by timeout.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   enable       capture active when 1
//   clear        one-cycle pulse, zeroes counts, measurements and flags
//   pulse_expect expected pulse total, 0 disables done/overrun
//   pto_in       asynchronous pulse-train input
//   pulse_count  saturating rising-edge count
//   period_us    last rising-to-rising interval in us
//   high_us      last high time in us
//   period_valid one-cycle strobe on period_us update
//   motion       0 stopped/idle, 1 accel, 2 cruise, 3 decel
//   count_done   sticky, pulse_count reached pulse_expect
//   overrun      sticky, pulse counted after count_done
module pto_capture #(
  parameter int CLK_PER_US  = 50,
  parameter int FILTER_CLKS = 4,
  parameter int TIMEOUT_US  = 6000,
  parameter int TOL_US      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] pulse_expect,
  input  logic        pto_in,
  output logic [31:0] pulse_count,
  output logic [31:0] period_us,
  output logic [31:0] high_us,
  output logic        period_valid,
  output logic [1:0]  motion,
  output logic        count_done,
  output logic        overrun
);
  localparam int PW = CLK_PER_US > 1 ? $clog2(CLK_PER_US) : 1;
  localparam logic signed [32:0] TOL_S = 33'(TOL_US);
  typedef enum logic [1:0] {IDLE, ARMED, RUNNING, STOPPED} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, filt_q, filt_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [31:0] per_q, per_d, hi_q, hi_d, prev_q, prev_d;
  logic [31:0] cnt_q, cnt_d, period_q, period_d, high_q, high_d;
  logic first_q, first_d, pv_q, pv_d, done_q, done_d, ovr_q, ovr_d;
  logic [1:0] motion_q, motion_d;
  logic flip, rise, fall, act, tick, edge_ok, tmo, rep;
  logic [31:0] per_nx, hi_nx, cnt_inc;
  logic signed [32:0] new_s, prev_s;
  logic [1:0] mot_nx;
  always_comb begin
    // filter flips only once FILTER_CLKS consecutive differing samples are seen
    flip = (s2_q != filt_q) && (fcnt_q == 8'(FILTER_CLKS - 1));
    rise = flip && !filt_q;
    fall = flip && filt_q;
    filt_d = flip ? s2_q : filt_q;
    fcnt_d = (s2_q == filt_q || flip) ? 8'd0 : fcnt_q + 8'd1;
    act = enable && state_q != IDLE;
    tick = act && pre_q == PW'(CLK_PER_US - 1);
    // latched measurements include the tick landing on the edge cycle itself
    per_nx = per_q + 32'(tick && per_q != '1);
    hi_nx = hi_q + 32'(tick && filt_q && hi_q != '1);
    cnt_inc = cnt_q + 32'(cnt_q != '1);
    edge_ok = act && rise && !clear;
    tmo = state_q == RUNNING && !rise && per_nx >= 32'(TIMEOUT_US);
    rep = edge_ok && state_q == RUNNING;
    new_s = {1'b0, per_nx};
    prev_s = {1'b0, prev_q};
    mot_nx = first_q ? 2'd2 : (new_s < prev_s - TOL_S) ? 2'd1 : (new_s > prev_s + TOL_S) ? 2'd3 : 2'd2;
    state_d = !enable ? IDLE : clear ? ARMED : state_q == IDLE ? ARMED :
              state_q != RUNNING ? (rise ? RUNNING : state_q) : tmo ? STOPPED : RUNNING;
    pre_d = pre_q;
    per_d = per_q;
    hi_d = hi_q;
    prev_d = prev_q;
    cnt_d = cnt_q;
    period_d = period_q;
    high_d = high_q;
    first_d = first_q;
    pv_d = 1'b0;
    done_d = done_q;
    ovr_d = ovr_q;
    motion_d = motion_q;
    if (act) begin
      pre_d = (rise || tick) ? '0 : pre_q + PW'(1);
      per_d = rise ? '0 : per_nx;
      hi_d = rise ? '0 : hi_nx;
      if (fall) high_d = hi_nx;
      if (tmo) motion_d = 2'd0;
    end
    if (edge_ok) begin
      cnt_d = cnt_inc;
      if (pulse_expect != '0 && cnt_q != '1 && cnt_inc == pulse_expect) done_d = 1'b1;
      if (done_q) ovr_d = 1'b1;
      if (state_q != RUNNING) first_d = 1'b1;
    end
    if (rep) begin
      period_d = per_nx;
      pv_d = 1'b1;
      prev_d = per_nx;
      motion_d = mot_nx;
      first_d = 1'b0;
    end
    if (clear) begin
      pre_d = '0;
      per_d = '0;
      hi_d = '0;
      prev_d = '0;
      cnt_d = '0;
      period_d = '0;
      high_d = '0;
      first_d = 1'b0;
      pv_d = 1'b0;
      done_d = 1'b0;
      ovr_d = 1'b0;
      motion_d = 2'd0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      filt_q <= 1'b0;
      fcnt_q <= '0;
      pre_q <= '0;
      per_q <= '0;
      hi_q <= '0;
      prev_q <= '0;
      cnt_q <= '0;
      period_q <= '0;
      high_q <= '0;
      first_q <= 1'b0;
      pv_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      motion_q <= 2'd0;
    end else begin
      state_q <= state_d;
      s1_q <= pto_in;
      s2_q <= s1_q;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      pre_q <= pre_d;
      per_q <= per_d;
      hi_q <= hi_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      high_q <= high_d;
      first_q <= first_d;
      pv_q <= pv_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
      motion_q <= motion_d;
    end
  end
  assign pulse_count = cnt_q;
  assign period_us = period_q;
  assign high_us = high_q;
  assign period_valid = pv_q;
  assign motion = motion_q;
  assign count_done = done_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_pto_capture.sv
// tb_pto_capture: directed-vector bench for pto_capture with a short microsecond tick.
module tb_pto_capture;
  localparam int CPU = 2;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, clear = 1'b0, pto_in = 1'b0;
  logic [31:0] pulse_expect = '0;
  logic [31:0] pulse_count, period_us, high_us;
  logic period_valid, count_done, overrun;
  logic [1:0] motion;
  int nvec = 0, nerr = 0, nv = 0, b = 0;
  int hist_per[128], hist_mot[128];
  pto_capture #(.CLK_PER_US(CPU), .FILTER_CLKS(4), .TIMEOUT_US(6000), .TOL_US(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .pulse_expect(pulse_expect),
    .pto_in(pto_in), .pulse_count(pulse_count), .period_us(period_us), .high_us(high_us),
    .period_valid(period_valid), .motion(motion), .count_done(count_done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (period_valid && nv < 128) begin
      hist_per[nv] = period_us;
      hist_mot[nv] = motion;
      nv++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pulse(input int p, input int h);
    pto_in = 1'b1;
    repeat (h * CPU) @(posedge clk);
    #1 pto_in = 1'b0;
    repeat ((p - h) * CPU) @(posedge clk);
    #1;
  endtask
  task automatic do_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, pulse_count, 0);
    chk({tag, "_per"}, period_us, 0);
    chk({tag, "_high"}, high_us, 0);
    chk({tag, "_flags"}, {27'd0, period_valid, motion, count_done, overrun}, 0);
  endtask
  initial begin
    #12 chk_zero("rst0");
    @(posedge clk);
    #1 rst = 1'b1;
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    b = nv;
    pulse(100, 50);
    chk("t2_first_no_pv", nv - b, 0);
    repeat (9) pulse(100, 50);
    chk("t2_count", pulse_count, 10);
    chk("t2_strobes", nv - b, 9);
    chk("t2_period", period_us, 100);
    chk("t2_high", high_us, 50);
    chk("t2_mot1", hist_mot[b], 2);
    chk("t2_mot2", hist_mot[b + 1], 2);
    chk("t2_per_last", hist_per[b + 8], 100);
    do_clear();
    b = nv;
    for (int p = 250; p >= 200; p -= 2) pulse(p, p / 2);
    pulse(100, 50);
    pulse(102, 51);
    pulse(104, 52);
    pulse(100, 50);
    pulse(100, 50);
    pulse(100, 50);
    chk("t3_strobes", nv - b, 31);
    chk("t3_first", hist_mot[b], 2);
    for (int i = 1; i <= 25; i++) chk("t3_accel", hist_mot[b + i], 1);
    chk("t3_per200", hist_per[b + 25], 200);
    chk("t3_drop100", hist_mot[b + 26], 1);
    chk("t3_decel102", hist_mot[b + 27], 3);
    chk("t3_per102", hist_per[b + 27], 102);
    chk("t3_decel104", hist_mot[b + 28], 3);
    chk("t3_back100", hist_mot[b + 29], 1);
    chk("t3_cruise", hist_mot[b + 30], 2);
    do_clear();
    chk("t4_cleared", pulse_count, 0);
    pulse_expect = 5;
    for (int i = 1; i <= 6; i++) begin
      pulse(40, 20);
      if (i == 4) chk("t4_done4", count_done, 0);
      if (i == 5) begin
        chk("t4_done5", count_done, 1);
        chk("t4_ovr5", overrun, 0);
      end
    end
    chk("t4_ovr6", overrun, 1);
    chk("t4_done6", count_done, 1);
    do_clear();
    chk("t4_done_clr", count_done, 0);
    chk("t4_ovr_clr", overrun, 0);
    pulse_expect = 0;
    repeat (4) pulse(200, 100);
    pto_in = 1'b1;
    repeat (100 * CPU) @(posedge clk);
    #1 pto_in = 1'b0;
    repeat (5890 * CPU) @(posedge clk);
    #1 chk("t5_before_tmo", motion, 2);
    repeat (20 * CPU) @(posedge clk);
    #1 chk("t5_stopped", motion, 0);
    b = nv;
    repeat (990 * CPU) @(posedge clk);
    #1;
    pulse(200, 100);
    chk("t5_count6", pulse_count, 6);
    chk("t5_no_pv", nv - b, 0);
    pulse(200, 100);
    chk("t5_one_pv", nv - b, 1);
    chk("t5_period", period_us, 200);
    chk("t5_motion", motion, 2);
    do_clear();
    repeat (20) @(posedge clk);
    #1 pto_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 pto_in = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t6_glitch3", pulse_count, 0);
    pto_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 pto_in = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t6_pulse5", pulse_count, 1);
    pto_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("t6_clr_edge", pulse_count, 0);
    pto_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    pulse(20, 10);
    chk("t6_after", pulse_count, 1);
    do_clear();
    repeat (37) pulse(20, 10);
    chk("t1_count37", pulse_count, 37);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("t1_async");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pulse(20, 10);
    pulse(20, 10);
    chk("t1_rearm_cnt", pulse_count, 2);
    chk("t1_rearm_per", period_us, 20);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
